fp_posit_acc: RTL and testbench

Bit-serial FP×posit MAC accumulation stage. Consumes the per-product result of `fp_posit_mul`: `sign_out`, `exp_out` and the 14-bit 4.10 fixed-point `mantissa_out`, qualified by its `done` pulse. Products are accumulated exactly in a wide two's-complement register. At the end of a dot product the block normalises the sum and returns an FP16 result through a valid/ready handshake.

---
 rtl/fp_posit_acc.sv | 237 +++++++++++++++++++++++
 tb/tb_fp_posit_acc.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_posit_acc.sv
// fp_posit_acc
//   Accumulation stage behind fp_posit_mul. Each product is added exactly into
//   a wide two's-complement accumulator in units of 2^-25. At the end of a dot
//   product the sum is normalised and returned as an FP16 word through a
//   valid/ready handshake.
//
//   Optional feature macro: FP_POSIT_ACC_RNE_EN
//     defined   -> round-to-nearest-even when packing the FP16 fraction
//     undefined -> fraction is truncated (round toward zero)
//
// Ports
//   clk        clock
//   rst        asynchronous, active-low reset
//   in_valid   product valid (multiplier done)
//   in_sign    product sign, 1 = negative
//   in_exp     product exponent, bias 15
//   in_man     product magnitude, unsigned 4.10 fixed point
//   in_last    final product of the dot product, sampled with in_valid
//   in_ready   block accepts a product this cycle
//   out_valid  out_data holds the FP16 result
//   out_data   FP16 result {sign, exp[4:0], frac[9:0]}
//   out_ovf    accumulator overflowed during this dot product
//   out_ready  consumer accepts the result
module fp_posit_acc #(
  parameter int ACC_WIDTH = 52
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        in_sign,
  input  logic [4:0]  in_exp,
  input  logic [13:0] in_man,
  input  logic        in_last,
  output logic        in_ready,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic        out_ovf,
  input  logic        out_ready
);

  localparam int KW = $clog2(ACC_WIDTH);
  localparam int EW = KW + 2;
  localparam int MSB = ACC_WIDTH - 1;
  localparam logic signed [EW-1:0] E_INF  = EW'(31);
  localparam logic signed [EW-1:0] E_ZERO = '0;

  typedef enum logic [2:0] {
    ST_ACC  = 3'd0,
    ST_ABS  = 3'd1,
    ST_NORM = 3'd2,
    ST_PACK = 3'd3,
    ST_OUT  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [ACC_WIDTH-1:0]  mag_q, mag_d;
  logic [KW-1:0]         k_q, k_d;
  logic                  ovf_q, ovf_d;
  logic                  ovf_sign_q, ovf_sign_d;
  logic                  sgn_q, sgn_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic [15:0]           out_data_q, out_data_d;
  logic                  out_ovf_q, out_ovf_d;

  logic [ACC_WIDTH-1:0]  addend_s;
  logic [ACC_WIDTH-1:0]  sum_s;
  logic [ACC_WIDTH-1:0]  abs_s;
  logic                  add_ovf_s;
  logic signed [EW-1:0]  exp_s;
  logic [9:0]            frac_s;
  logic [15:0]           packed_s;
`ifdef FP_POSIT_ACC_RNE_EN
  logic                  rnd_up_s;
  logic [10:0]           frac_rnd_s;
  logic signed [EW-1:0]  exp_rnd_s;
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

  // Datapath: exact product alignment, signed add with overflow flag, magnitude.
  always_comb begin
    addend_s = {{(ACC_WIDTH-14){1'b0}}, in_man} << in_exp;
    if (in_sign) begin
      sum_s     = acc_q - addend_s;
      // subtracting a non-negative value can only overflow from a negative acc
      add_ovf_s = acc_q[MSB] & ~sum_s[MSB];
    end else begin
      sum_s     = acc_q + addend_s;
      add_ovf_s = ~acc_q[MSB] & sum_s[MSB];
    end
    if (acc_q[MSB]) begin
      abs_s = ~acc_q + ACC_WIDTH'(1);
    end else begin
      abs_s = acc_q;
    end
  end

  // FP16 packing of the normalised magnitude (MSB of mag_q is the hidden one).
  always_comb begin
    frac_s = mag_q[ACC_WIDTH-2 -: 10];
    exp_s  = EW'(ACC_WIDTH - 11) - EW'(k_q);
`ifdef FP_POSIT_ACC_RNE_EN
    rnd_up_s   = mag_q[ACC_WIDTH-12] & ((|mag_q[ACC_WIDTH-13:0]) | frac_s[0]);
    frac_rnd_s = {1'b0, frac_s} + {10'd0, rnd_up_s};
    // a fraction carry-out bumps the exponent; the fraction wraps to zero
    exp_rnd_s  = exp_s + {{(EW-1){1'b0}}, frac_rnd_s[10]};
    if (exp_s <= E_ZERO) begin
      packed_s = {sgn_q, 15'h0000};
    end else if (exp_rnd_s >= E_INF) begin
      packed_s = {sgn_q, 5'h1F, 10'h000};
    end else begin
      packed_s = {sgn_q, exp_rnd_s[4:0], frac_rnd_s[9:0]};
    end
`else
    if (exp_s >= E_INF) begin
      packed_s = {sgn_q, 5'h1F, 10'h000};
    end else if (exp_s <= E_ZERO) begin
      packed_s = {sgn_q, 15'h0000};
    end else begin
      packed_s = {sgn_q, exp_s[4:0], frac_s};
    end
`endif
  end

  // Next-state logic for the control FSM and all registered outputs.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    mag_d       = mag_q;
    k_d         = k_q;
    ovf_d       = ovf_q;
    ovf_sign_d  = ovf_sign_q;
    sgn_d       = sgn_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    case (state_q)
      ST_ACC: begin
        if (in_valid) begin
          acc_d = sum_s;
          // only the first overflow defines the saturation sign
          if (add_ovf_s && !ovf_q) begin
            ovf_d      = 1'b1;
            ovf_sign_d = in_sign;
          end else begin
            ovf_d      = ovf_q;
            ovf_sign_d = ovf_sign_q;
          end
          if (in_last) begin
            state_d = ST_ABS;
          end else begin
            state_d = ST_ACC;
          end
        end else begin
          state_d = ST_ACC;
        end
      end
      ST_ABS: begin
        mag_d   = abs_s;
        sgn_d   = acc_q[MSB];
        k_d     = '0;
        state_d = ST_NORM;
      end
      ST_NORM: begin
        // zero and overflowed sums also take this one cycle so the result
        // latency is always 3 + shift count after the last product
        if (ovf_q || (mag_q == '0) || mag_q[MSB]) begin
          state_d = ST_PACK;
        end else begin
          mag_d   = mag_q << 1;
          k_d     = k_q + KW'(1);
          state_d = ST_NORM;
        end
      end
      ST_PACK: begin
        if (ovf_q) begin
          out_data_d = {ovf_sign_q, 5'h1F, 10'h000};
        end else if (mag_q == '0) begin
          out_data_d = 16'h0000;
        end else begin
          out_data_d = packed_s;
        end
        out_ovf_d = ovf_q;
        state_d   = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          acc_d      = '0;
          ovf_d      = 1'b0;
          ovf_sign_d = 1'b0;
          state_d    = ST_ACC;
        end else begin
          state_d    = ST_OUT;
        end
      end
      default: begin
        state_d = ST_ACC;
      end
    endcase
    in_ready_d  = (state_d == ST_ACC);
    out_valid_d = (state_d == ST_OUT);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_ACC;
      acc_q       <= '0;
      mag_q       <= '0;
      k_q         <= '0;
      ovf_q       <= 1'b0;
      ovf_sign_q  <= 1'b0;
      sgn_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= 16'h0000;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      mag_q       <= mag_d;
      k_q         <= k_d;
      ovf_q       <= ovf_d;
      ovf_sign_q  <= ovf_sign_d;
      sgn_q       <= sgn_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_fp_posit_acc.sv
// Self-checking bench for fp_posit_acc. Reference model works on the exact
// integer sum (64-bit) and derives the FP16 word from the position of the
// leading one, independent of the block's shift-based normaliser.
module tb_fp_posit_acc;

  localparam int AW = 52;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_sign;
  logic [4:0]  in_exp;
  logic [13:0] in_man;
  logic        in_last;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ovf;
  logic        out_ready;

  typedef struct {
    bit        s;
    bit [4:0]  e;
    bit [13:0] m;
  } prod_t;

  prod_t plist[$];
  int    vectors;
  int    fails;

  fp_posit_acc #(.ACC_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_man    (in_man),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic prod_t mk(input bit s, input bit [4:0] e, input bit [13:0] m);
    prod_t p;
    p.s = s;
    p.e = e;
    p.m = m;
    return p;
  endfunction

  // Exact reference: sum the products as integers, then build FP16.
  task automatic model_result(output logic [15:0] res, output bit ovf, output int n);
    longint sum;
    longint lim;
    longint mag;
    longint frac;
    bit     osign;
    bit     sg;
    int     p;
    int     e;
`ifdef FP_POSIT_ACC_RNE_EN
    longint rem;
    longint half;
`endif
    sum   = 0;
    lim   = 64'sd1 <<< (AW - 1);
    osign = 1'b0;
    ovf   = 1'b0;
    n     = 0;
    foreach (plist[i]) begin
      if (!ovf) begin
        longint v;
        v = longint'(plist[i].m) << plist[i].e;
        sum = plist[i].s ? sum - v : sum + v;
        if (sum >= lim || sum < -lim) begin
          ovf   = 1'b1;
          osign = plist[i].s;
        end
      end
    end
    if (ovf) begin
      res = {osign, 5'h1F, 10'h000};
    end else if (sum == 0) begin
      res = 16'h0000;
    end else begin
      sg  = (sum < 0);
      mag = sg ? -sum : sum;
      p   = 0;
      for (int i = 0; i < 62; i++) if (mag[i]) p = i;
      n = AW - 1 - p;
      e = p - 10;
      if (e >= 31) begin
        res = {sg, 5'h1F, 10'h000};
      end else if (e <= 0) begin
        res = {sg, 15'h0000};
      end else begin
        frac = (mag >> (p - 10)) & 64'd1023;
`ifdef FP_POSIT_ACC_RNE_EN
        rem  = mag - ((mag >> (p - 10)) << (p - 10));
        half = 64'sd1 <<< (p - 11);
        if (rem > half || (rem == half && frac[0])) begin
          frac = frac + 1;
          if (frac == 1024) begin
            frac = 0;
            e    = e + 1;
          end
        end
`endif
        if (e >= 31) res = {sg, 5'h1F, 10'h000};
        else         res = {sg, 5'(e), 10'(frac)};
      end
    end
  endtask

  // Drive every product of plist on consecutive cycles, last flag on the final one.
  task automatic send_list(input string nm);
    foreach (plist[i]) begin
      in_valid = 1'b1;
      in_sign  = plist[i].s;
      in_exp   = plist[i].e;
      in_man   = plist[i].m;
      in_last  = (i == plist.size() - 1);
      vectors++;
      if (in_ready !== 1'b1) begin
        fails++;
        $display("FAIL %s in_ready before product %0d: got %b, expected 1", nm, i, in_ready);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_result(input string nm, input int n_exp, input logic [15:0] d_exp, input bit o_exp);
    int cyc;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    vectors++;
    if (cyc != 3 + n_exp) begin
      fails++;
      $display("FAIL %s latency: got %0d cycles, expected %0d", nm, cyc, 3 + n_exp);
    end
    vectors++;
    if (out_data !== d_exp) begin
      fails++;
      $display("FAIL %s out_data: got %h, expected %h", nm, out_data, d_exp);
    end
    vectors++;
    if (out_ovf !== o_exp) begin
      fails++;
      $display("FAIL %s out_ovf: got %b, expected %b", nm, out_ovf, o_exp);
    end
  endtask

  task automatic handshake(input string nm, input logic [15:0] d_exp);
    int w;
    w = $urandom_range(0, 3);
    repeat (w) begin
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b1 || out_data !== d_exp) begin
        fails++;
        $display("FAIL %s hold: got valid=%b data=%h, expected valid=1 data=%h", nm, out_valid, out_data, d_exp);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL %s after handshake: got in_ready=%b out_valid=%b, expected 1/0", nm, in_ready, out_valid);
    end
  endtask

  task automatic run_dot(input string nm, input int want);
    logic [15:0] d;
    bit          o;
    int          n;
    model_result(d, o, n);
    send_list(nm);
    wait_result(nm, n, d, o);
    if (want >= 0) begin
      vectors++;
      if (out_data !== 16'(want)) begin
        fails++;
        $display("FAIL %s directed value: got %h, expected %h", nm, out_data, 16'(want));
      end
    end
    handshake(nm, d);
  endtask

  task automatic test_reset;
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 16'h0000 || out_ovf !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset outputs: got valid=%b data=%h ovf=%b ready=%b, expected 0/0000/0/1",
               out_valid, out_data, out_ovf, in_ready);
    end
  endtask

  task automatic test_directed;
    plist = {mk(1'b0, 5'd15, 14'h400)};
    run_dot("one", 32'h3C00);
    plist = {mk(1'b0, 5'd15, 14'h600), mk(1'b0, 5'd13, 14'h400)};
    run_dot("one_75", 32'h3F00);
    plist = {mk(1'b0, 5'd15, 14'h400), mk(1'b1, 5'd15, 14'h400)};
    run_dot("cancel_zero", 32'h0000);
    plist = {mk(1'b0, 5'd31, 14'h400)};
    run_dot("big_inf", 32'h7C00);
    plist = {mk(1'b0, 5'd15, 14'h400), mk(1'b0, 5'd4, 14'h600)};
`ifdef FP_POSIT_ACC_RNE_EN
    run_dot("round", 32'h3C01);
`else
    run_dot("round", 32'h3C00);
`endif
    plist = {mk(1'b1, 5'd0, 14'h001)};
    run_dot("tiny_neg_flush", 32'h8000);
    plist = {mk(1'b1, 5'd14, 14'h400)};
    run_dot("neg_half", 32'hB800);
  endtask

  task automatic test_overflow;
    plist = {};
    for (int i = 0; i < 70; i++) plist.push_back(mk(1'b0, 5'd31, 14'h3FFF));
    run_dot("ovf_pos", 32'h7C00);
    plist = {};
    for (int i = 0; i < 70; i++) plist.push_back(mk(1'b1, 5'd31, 14'h3FFF));
    run_dot("ovf_neg", 32'hFC00);
  endtask

  task automatic test_random;
    for (int t = 0; t < 30; t++) begin
      int len;
      len = $urandom_range(1, 6);
      plist = {};
      for (int i = 0; i < len; i++) begin
        plist.push_back(mk(1'($urandom_range(0, 1)),
                           5'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(5, 24)),
                           14'($urandom_range(0, 16383))));
      end
      // stray last flag without valid must be ignored
      in_last = 1'b1;
      @(posedge clk); #1;
      in_last = 1'b0;
      run_dot($sformatf("rand%0d", t), -1);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] d;
    bit          o;
    int          n;
    plist = {mk(1'b0, 5'd15, 14'h600), mk(1'b0, 5'd13, 14'h400)};
    model_result(d, o, n);
    send_list("bp");
    wait_result("bp", n, d, o);
    in_valid = 1'b1;
    in_sign  = 1'b0;
    in_exp   = 5'd15;
    in_man   = 14'h400;
    in_last  = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      vectors++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== d) begin
        fails++;
        $display("FAIL bp stall: got ready=%b valid=%b data=%h, expected 0/1/%h", in_ready, out_valid, out_data, d);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp release: got ready=%b valid=%b, expected 1/0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    plist = {mk(1'b0, 5'd15, 14'h400)};
    model_result(d, o, n);
    wait_result("bp_next", n, d, o);
    vectors++;
    if (out_data !== 16'h3C00) begin
      fails++;
      $display("FAIL bp_next fresh sum: got %h, expected 3c00", out_data);
    end
    handshake("bp_next", d);
  endtask

  task automatic test_reset_mid_norm;
    plist = {mk(1'b0, 5'd20, 14'h400), mk(1'b0, 5'd15, 14'h400)};
    send_list("rst_norm");
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 16'h0000) begin
      fails++;
      $display("FAIL rst_norm in reset: got valid=%b ready=%b data=%h, expected 0/1/0000", out_valid, in_ready, out_data);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_norm after release: got valid=%b ready=%b, expected 0/1", out_valid, in_ready);
    end
    plist = {mk(1'b0, 5'd14, 14'h400)};
    run_dot("rst_fresh", 32'h3800);
  endtask

  initial begin
    vectors   = 0;
    fails     = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = 5'd0;
    in_man    = 14'd0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    test_reset;
    test_directed;
    test_overflow;
    test_random;
    test_back_to_back;
    test_reset_mid_norm;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
